// File: rtl/slew_pkg.sv
// Shared types, slewing codes and fixed-point quantisation helper for the
// slew-rate limiter. Values are mantissa * 2^exponent.
package slew_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UP    = 2'd1,
    DOWN  = 2'd2,
    TRACK = 2'd3
  } slew_state_t;

  localparam logic [1:0] SLEW_NONE = 2'b00;
  localparam logic [1:0] SLEW_UP   = 2'b01;
  localparam logic [1:0] SLEW_DOWN = 2'b10;

  // Quantise a real to a mantissa with LSB weight 2^expo: round half away
  // from zero, saturate symmetrically to +/-(2^(width-1)-1).
  function automatic int quant_real(real x, int expo, int width);
    real scaled;
    real lim;
    int  q;
    scaled = x;
    if (expo < 0) begin
      for (int i = 0; i < -expo; i++) scaled = scaled * 2.0;
    end else begin
      for (int i = 0; i < expo; i++) scaled = scaled / 2.0;
    end
    lim = 1.0;
    for (int i = 0; i < width - 1; i++) lim = lim * 2.0;
    lim = lim - 1.0;
    if (scaled > lim) scaled = lim;
    else if (scaled < -lim) scaled = -lim;
    if (scaled >= 0.0) q = $rtoi(scaled + 0.5);
    else q = $rtoi(scaled - 0.5);
    return q;
  endfunction

endpackage

// File: rtl/real_align_sat.sv
// Combinational exponent alignment between two fixed-point formats.
// Left shifts saturate to the symmetric output range; right shifts are
// arithmetic (truncate toward -inf) and are saturated the same way in case
// the output is narrower than the shifted input.
module real_align_sat #(
  parameter int IN_WIDTH  = 18,
  parameter int IN_EXP    = -12,
  parameter int OUT_WIDTH = 18,
  parameter int OUT_EXP   = -12
) (
  input  logic [IN_WIDTH-1:0]  in,
  output logic [OUT_WIDTH-1:0] out
);

  localparam int SHIFT = IN_EXP - OUT_EXP;
  localparam int LSH   = (SHIFT > 0) ? SHIFT : 0;
  // Wide enough to hold any shifted input plus the output range without wrap.
  localparam int WW    = IN_WIDTH + OUT_WIDTH + LSH;

  localparam logic signed [WW-1:0] MAX_W = {{(WW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [WW-1:0] MIN_W = -MAX_W;

  logic signed [WW-1:0] ext;
  logic signed [WW-1:0] shifted;

  assign ext = {{(WW - IN_WIDTH){in[IN_WIDTH-1]}}, in};

  generate
    if (SHIFT >= 0) begin : g_left
      assign shifted = ext <<< SHIFT;
    end else begin : g_right
      assign shifted = ext >>> (-SHIFT);
    end
  endgenerate

  // Clamp the aligned value into the output mantissa range.
  always_comb begin
    if (shifted > MAX_W)      out = MAX_W[OUT_WIDTH-1:0];
    else if (shifted < MIN_W) out = MIN_W[OUT_WIDTH-1:0];
    else                      out = shifted[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/slew_limit_real.sv
// Fixed-point slew-rate limiter: each enabled cycle the output moves toward
// the latest latched target by at most STEP LSBs, landing exactly on it.
// Reports slewing direction and a settled flag after SETTLE_CYCLES on target.
module slew_limit_real
  import slew_pkg::*;
#(
  parameter int  IN_WIDTH      = 18,
  parameter int  IN_EXP        = -12,
  parameter int  OUT_WIDTH     = 18,
  parameter int  OUT_EXP       = -12,
  parameter real MAX_STEP      = 0.25,
  parameter real INIT          = 0.0,
  parameter int  SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cke,
  input  logic [IN_WIDTH-1:0]  in,
  input  logic                 in_valid,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 out_valid,
  output logic [1:0]           slewing,
  output logic                 settled
);

  localparam int DW     = OUT_WIDTH + 2;
  localparam int STEP   = quant_real(MAX_STEP, OUT_EXP, OUT_WIDTH);
  localparam int INIT_Q = quant_real(INIT, OUT_EXP, OUT_WIDTH);
  localparam int CW     = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

  localparam logic signed [DW-1:0]  STEP_W     = DW'(STEP);
  localparam logic [OUT_WIDTH-1:0]  STEP_O     = OUT_WIDTH'(STEP);
  localparam logic [OUT_WIDTH-1:0]  INIT_W     = OUT_WIDTH'(INIT_Q);
  localparam logic [CW-1:0]         SETTLE_MAX = CW'(SETTLE_CYCLES);

  generate
    if (STEP < 1 || SETTLE_CYCLES < 1) begin : g_bad_cfg
      $fatal(1, "slew_limit_real: quantised MAX_STEP must be >= 1 LSB and SETTLE_CYCLES >= 1");
    end
  endgenerate

  logic [OUT_WIDTH-1:0] aligned;

  real_align_sat #(
    .IN_WIDTH (IN_WIDTH),
    .IN_EXP   (IN_EXP),
    .OUT_WIDTH(OUT_WIDTH),
    .OUT_EXP  (OUT_EXP)
  ) u_align (
    .in (in),
    .out(aligned)
  );

  slew_state_t          state_reg, state_next;
  logic [OUT_WIDTH-1:0] out_reg, out_next;
  logic [OUT_WIDTH-1:0] target_reg, target_next;
  logic [CW-1:0]        settle_cnt_reg, settle_cnt_next;
  logic                 out_valid_reg, out_valid_next;
  logic                 settled_reg, settled_next;
  logic [OUT_WIDTH-1:0] t;
  logic signed [DW-1:0] diff;

  // Step computation: a fresh target is used on the edge it arrives, and IDLE
  // holds the output until the first accepted target.
  always_comb begin
    state_next     = state_reg;
    out_next       = out_reg;
    target_next    = target_reg;
    out_valid_next = out_valid_reg | in_valid;
    t              = in_valid ? aligned : target_reg;
    diff           = {{2{t[OUT_WIDTH-1]}}, t} - {{2{out_reg[OUT_WIDTH-1]}}, out_reg};

    if (state_reg != IDLE || in_valid) begin
      if (in_valid) target_next = aligned;
      if (diff > STEP_W) begin
        out_next   = out_reg + STEP_O;
        state_next = UP;
      end else if (diff < -STEP_W) begin
        out_next   = out_reg - STEP_O;
        state_next = DOWN;
      end else begin
        out_next   = t;
        state_next = TRACK;
      end
    end

    // A new target that differs from the current output restarts the count,
    // even if the output reaches it on this same edge.
    if (state_next != TRACK || (in_valid && aligned != out_reg)) begin
      settle_cnt_next = '0;
    end else if (settle_cnt_reg != SETTLE_MAX) begin
      settle_cnt_next = settle_cnt_reg + CW'(1);
    end else begin
      settle_cnt_next = settle_cnt_reg;
    end
    settled_next = (settle_cnt_next == SETTLE_MAX);
  end

  // State and datapath registers; cke low freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      out_reg        <= INIT_W;
      target_reg     <= INIT_W;
      settle_cnt_reg <= '0;
      out_valid_reg  <= 1'b0;
      settled_reg    <= 1'b0;
    end else if (cke) begin
      state_reg      <= state_next;
      out_reg        <= out_next;
      target_reg     <= target_next;
      settle_cnt_reg <= settle_cnt_next;
      out_valid_reg  <= out_valid_next;
      settled_reg    <= settled_next;
    end
  end

  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign settled   = settled_reg;
  assign slewing   = (state_reg == UP)   ? SLEW_UP   :
                     (state_reg == DOWN) ? SLEW_DOWN : SLEW_NONE;

endmodule

// File: tb/tb_slew_limit_real.sv
// Directed bench for slew_limit_real: default-format instance plus a second
// instance with a coarser input exponent to exercise left-shift saturation.
module tb_slew_limit_real;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cke = 1'b1;
  logic in_valid = 1'b0;
  logic in_valid_b = 1'b0;
  logic signed [17:0] in = '0;
  logic signed [17:0] in_b = '0;

  logic signed [17:0] out, out_b;
  logic out_valid, out_valid_b, settled, settled_b;
  logic [1:0] slewing, slewing_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  slew_limit_real dut (
    .clk(clk), .rst_n(rst_n), .cke(cke), .in(in), .in_valid(in_valid),
    .out(out), .out_valid(out_valid), .slewing(slewing), .settled(settled)
  );

  slew_limit_real #(.IN_EXP(-10)) dut_b (
    .clk(clk), .rst_n(rst_n), .cke(cke), .in(in_b), .in_valid(in_valid_b),
    .out(out_b), .out_valid(out_valid_b), .slewing(slewing_b), .settled(settled_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse between clock edges, checked before any edge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_out"}, int'(out), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_slewing"}, int'(slewing), 0);
    check({tag, "_settled"}, int'(settled), 0);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    // Reset without any clock edge
    #1 rst_n = 1'b0;
    #1;
    check("rst_out", int'(out), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_slewing", int'(slewing), 0);
    check("rst_settled", int'(settled), 0);
    tick();
    rst_n = 1'b1;

    // IDLE holds without in_valid
    tick();
    check("idle_out", int'(out), 0);
    check("idle_out_valid", int'(out_valid), 0);

    // Step up to 2.5
    in = 18'sd10240;
    in_valid = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k <= 10) begin
        check($sformatf("up_out[%0d]", k), int'(out), 1024 * k);
        check($sformatf("up_slew[%0d]", k), int'(slewing), (k < 10) ? 1 : 0);
      end else begin
        check($sformatf("up_hold[%0d]", k), int'(out), 10240);
      end
      if (k == 1) check("up_out_valid", int'(out_valid), 1);
      if (k >= 10) check($sformatf("up_settled[%0d]", k), int'(settled), (k == 14) ? 1 : 0);
    end

    // Reversal to -2.5
    in = -18'sd10240;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("rev_out[%0d]", k), int'(out), 10240 - 1024 * k);
      check($sformatf("rev_slew[%0d]", k), int'(slewing), (k < 20) ? 2 : 0);
      if (k == 1) check("rev_settled", int'(settled), 0);
    end

    async_reset("rst_a");

    // Single-pulse target, later input ignored
    in = 18'sd4096;
    in_valid = 1'b1;
    tick();
    check("pulse_out[1]", int'(out), 1024);
    check("pulse_slew[1]", int'(slewing), 1);
    in_valid = 1'b0;
    in = -18'sd50000;
    for (int k = 2; k <= 7; k++) begin
      tick();
      check($sformatf("pulse_out[%0d]", k), int'(out), (k <= 4) ? 1024 * k : 4096);
      check($sformatf("pulse_slew[%0d]", k), int'(slewing), (k < 4) ? 1 : 0);
      check($sformatf("pulse_settled[%0d]", k), int'(settled), (k == 7) ? 1 : 0);
    end

    async_reset("rst_b");

    // cke gating mid-slew
    in = 18'sd10240;
    in_valid = 1'b1;
    tick();
    tick();
    check("cke_pre_out", int'(out), 2048);
    cke = 1'b0;
    in = -18'sd10240;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("cke_hold_out[%0d]", k), int'(out), 2048);
      check($sformatf("cke_hold_slew[%0d]", k), int'(slewing), 1);
    end
    cke = 1'b1;
    in = 18'sd10240;
    tick();
    check("cke_resume_out", int'(out), 3072);
    check("cke_resume_slew", int'(slewing), 1);

    async_reset("rst_c");

    // Settle at 0, then small and partial moves
    in = 18'sd0;
    in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("zero_out[%0d]", k), int'(out), 0);
      check($sformatf("zero_settled[%0d]", k), int'(settled), (k == 4) ? 1 : 0);
    end
    in = 18'sd410;
    tick();
    check("small_out", int'(out), 410);
    check("small_slew", int'(slewing), 0);
    check("small_settled", int'(settled), 0);
    in = 18'sd2000;
    tick();
    check("part_out[1]", int'(out), 1434);
    check("part_slew[1]", int'(slewing), 1);
    tick();
    check("part_out[2]", int'(out), 2000);
    check("part_slew[2]", int'(slewing), 0);
    in = -18'sd200;
    tick();
    check("neg_out[1]", int'(out), 976);
    check("neg_slew[1]", int'(slewing), 2);
    tick();
    check("neg_out[2]", int'(out), -48);
    check("neg_slew[2]", int'(slewing), 2);
    tick();
    check("neg_out[3]", int'(out), -200);
    check("neg_slew[3]", int'(slewing), 0);

    // Async reset mid-slew
    in = 18'sd10240;
    tick();
    tick();
    check("mid_out", int'(out), 1848);
    async_reset("rst_d");
    in_valid = 1'b0;

    // Format change on the IN_EXP=-10 instance: x4 left shift, then saturation
    in_b = 18'sd100;
    in_valid_b = 1'b1;
    tick();
    check("fmt_out", int'(out_b), 400);
    check("fmt_out_valid", int'(out_valid_b), 1);
    in_b = 18'sd131071;
    for (int k = 1; k <= 128; k++) begin
      tick();
      if (k == 127) begin
        check("sat_out[127]", int'(out_b), 130448);
        check("sat_slew[127]", int'(slewing_b), 1);
      end
      if (k == 128) begin
        check("sat_out[128]", int'(out_b), 131071);
        check("sat_slew[128]", int'(slewing_b), 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
